// File: rtl/tc_sram_mover.sv
// rtl/tc_sram_mover.sv - single-port SRAM initiator for fill, copy and read-check commands
module tc_sram_mover #(
    parameter int NumWords  = 32,
    parameter int DataWidth = 32,
    parameter int ByteWidth = 8,
    parameter int Latency   = 1,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int LenWidth  = $clog2(NumWords + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [AddrWidth-1:0] cmd_src_i,
    input  logic [AddrWidth-1:0] cmd_dst_i,
    input  logic [LenWidth-1:0]  cmd_len_i,
    input  logic [DataWidth-1:0] cmd_pattern_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [LenWidth-1:0]  err_cnt_o,
    output logic                 req_o,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic [BeWidth-1:0]   be_o,
    input  logic [DataWidth-1:0] rdata_i
);

    localparam int WaitWidth = (Latency > 1) ? $clog2(Latency) : 1;
    localparam logic [WaitWidth-1:0] WaitLast = WaitWidth'((Latency > 0) ? Latency - 1 : 0);
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic                   copy_q, copy_d;
    logic [LenWidth-1:0]    len_q, len_d;
    logic [LenWidth-1:0]    k_q, k_d;
    logic [LenWidth-1:0]    err_q, err_d;
    logic [DataWidth-1:0]   pat_q, pat_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [AddrWidth-1:0]   rd_addr_q, rd_addr_d;
    logic [AddrWidth-1:0]   wr_addr_q, wr_addr_d;
    logic [WaitWidth-1:0]   wait_q, wait_d;
    logic [AddrWidth-1:0]   addr_hold_q;
    logic [DataWidth-1:0]   wdata_hold_q;

    logic                   ready;
    logic                   last_word;
    logic                   capture;

    // Wrap at NumWords, which need not be a power of two.
    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a);
        return (a == LastAddr) ? '0 : a + AddrWidth'(1);
    endfunction

    assign last_word = (k_q + LenWidth'(1)) == len_q;

    always_comb begin
        state_d   = state_q;
        copy_d    = copy_q;
        len_d     = len_q;
        k_d       = k_q;
        err_d     = err_q;
        pat_d     = pat_q;
        data_d    = data_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wait_d    = wait_q;
        ready     = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        req_o     = 1'b0;
        we_o      = 1'b0;
        be_o      = '0;
        addr_o    = addr_hold_q;
        wdata_o   = wdata_hold_q;
        capture   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (cmd_valid_i) begin
                    copy_d    = (cmd_op_i == 2'd1);
                    len_d     = cmd_len_i;
                    pat_d     = cmd_pattern_i;
                    rd_addr_d = cmd_src_i;
                    wr_addr_d = cmd_dst_i;
                    k_d       = '0;
                    err_d     = '0;
                    if (cmd_len_i == '0 || cmd_op_i == 2'd3) begin
                        state_d = S_DONE;
                    end else if (cmd_op_i == 2'd0) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_FILL: begin
                busy_o    = 1'b1;
                req_o     = 1'b1;
                we_o      = 1'b1;
                be_o      = '1;
                addr_o    = wr_addr_q;
                wdata_o   = pat_q;
                wr_addr_d = next_addr(wr_addr_q);
                k_d       = k_q + LenWidth'(1);
                if (last_word) begin
                    state_d = S_DONE;
                end
            end
            S_RD: begin
                busy_o    = 1'b1;
                req_o     = 1'b1;
                addr_o    = rd_addr_q;
                rd_addr_d = next_addr(rd_addr_q);
                if (Latency == 0) begin
                    capture = 1'b1;
                end else begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                busy_o = 1'b1;
                if (wait_q == WaitLast) begin
                    capture = 1'b1;
                end else begin
                    wait_d = wait_q + WaitWidth'(1);
                end
            end
            S_WR: begin
                busy_o    = 1'b1;
                req_o     = 1'b1;
                we_o      = 1'b1;
                be_o      = '1;
                addr_o    = wr_addr_q;
                wdata_o   = data_q;
                wr_addr_d = next_addr(wr_addr_q);
                k_d       = k_q + LenWidth'(1);
                state_d   = last_word ? S_DONE : S_RD;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Shared by the RD cycle (zero latency) and the final WAIT cycle.
        if (capture) begin
            data_d = rdata_i;
            if (copy_q) begin
                state_d = S_WR;
            end else begin
                if (rdata_i != pat_q) begin
                    err_d = err_q + LenWidth'(1);
                end
                k_d     = k_q + LenWidth'(1);
                state_d = last_word ? S_DONE : S_RD;
            end
        end
    end

    assign cmd_ready_o = ready & ~rst_i;
    assign err_cnt_o   = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            copy_q       <= 1'b0;
            len_q        <= '0;
            k_q          <= '0;
            err_q        <= '0;
            pat_q        <= '0;
            data_q       <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wait_q       <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            copy_q       <= copy_d;
            len_q        <= len_d;
            k_q          <= k_d;
            err_q        <= err_d;
            pat_q        <= pat_d;
            data_q       <= data_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wait_q       <= wait_d;
            addr_hold_q  <= addr_o;
            wdata_hold_q <= wdata_o;
        end
    end

endmodule

// File: tb/tb_tc_sram_mover.sv
// tb/tb_tc_sram_mover.sv - self-checking bench: two movers (latency 1 and 0) each with its own SRAM model
module tb_tc_sram_mover;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_src, cmd_dst;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_pat;

    logic        r0, b0, dn0, q0, w0;
    logic        r1, b1, dn1, q1, w1;
    logic [5:0]  e0, e1;
    logic [4:0]  a0, a1;
    logic [31:0] wd0, wd1, rd0, rd1;
    logic [3:0]  be0, be1;

    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];
    logic [31:0] rd1_q;

    logic        d_ready, d_busy, d_done, d_req, d_we;
    logic [5:0]  d_err;
    logic [4:0]  d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;

    int          n_checks, n_err;
    logic [31:0] refm [2][32];
    int          m_la [2];
    bit          e_req [128];
    bit          e_we  [128];
    int          e_addr [128];
    logic [31:0] e_wd  [128];

    tc_sram_mover #(.Latency(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid & ~sel), .cmd_ready_o(r0),
        .cmd_op_i(cmd_op), .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len),
        .cmd_pattern_i(cmd_pat), .busy_o(b0), .done_o(dn0), .err_cnt_o(e0),
        .req_o(q0), .we_o(w0), .addr_o(a0), .wdata_o(wd0), .be_o(be0), .rdata_i(rd0)
    );

    tc_sram_mover #(.Latency(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid & sel), .cmd_ready_o(r1),
        .cmd_op_i(cmd_op), .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len),
        .cmd_pattern_i(cmd_pat), .busy_o(b1), .done_o(dn1), .err_cnt_o(e1),
        .req_o(q1), .we_o(w1), .addr_o(a1), .wdata_o(wd1), .be_o(be1), .rdata_i(rd1)
    );

    function automatic logic [31:0] bemask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    // SRAM models: zero-latency combinational read, and one-cycle registered read.
    assign rd0 = mem0[a0];
    always @(posedge clk) begin
        if (q0 && w0) mem0[a0] <= (mem0[a0] & ~bemask(be0)) | (wd0 & bemask(be0));
    end

    assign rd1 = rd1_q;
    always @(posedge clk) begin
        if (q1 && w1) mem1[a1] <= (mem1[a1] & ~bemask(be1)) | (wd1 & bemask(be1));
        if (q1 && !w1) rd1_q <= mem1[a1];
    end

    assign d_ready = sel ? r1  : r0;
    assign d_busy  = sel ? b1  : b0;
    assign d_done  = sel ? dn1 : dn0;
    assign d_req   = sel ? q1  : q0;
    assign d_we    = sel ? w1  : w0;
    assign d_err   = sel ? e1  : e0;
    assign d_addr  = sel ? a1  : a0;
    assign d_wdata = sel ? wd1 : wd0;
    assign d_be    = sel ? be1 : be0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int s, input int a);
        return (s == 1) ? mem1[a] : mem0[a];
    endfunction

    task automatic mem_cmp(input int s);
        int bad;
        bad = 0;
        for (int a = 0; a < 32; a++) if (mem_rd(s, a) !== refm[s][a]) bad++;
        chk("mem_contents", 32'(bad), 32'd0);
    endtask

    task automatic cmp_cycle(input int c, input int D, input int err);
        chk("ready", 32'(d_ready), 32'(c == 0 || c == D + 1));
        chk("busy",  32'(d_busy),  32'(c >= 1 && c < D));
        chk("done",  32'(d_done),  32'(c == D));
        chk("req",   32'(d_req),   32'(e_req[c]));
        chk("we",    32'(d_we),    32'(e_we[c]));
        chk("addr",  32'(d_addr),  e_addr[c]);
        if (e_we[c]) chk("wdata", d_wdata, e_wd[c]);
        if (e_we[c] || !e_req[c]) chk("be", 32'(d_be), e_we[c] ? 32'hF : 32'h0);
        if (c >= D) chk("err_cnt", 32'(d_err), err);
    endtask

    // Builds the expected per-cycle SRAM traffic from the command rules, then drives and checks it.
    task automatic run(input int s, input int op, input int src, input int dst, input int len,
                       input logic [31:0] pat, input bit junk, output int o_done, output int o_err);
        int L, W, D, lat, a, wa, c, cw, la, err;
        lat = s;
        L   = (op == 3) ? 0 : len;
        W   = (op == 0) ? 1 : (op == 1) ? lat + 2 : lat + 1;
        D   = L * W + 1;
        err = 0;
        for (int i = 0; i < 128; i++) begin
            e_req[i] = 0; e_we[i] = 0; e_addr[i] = 0; e_wd[i] = '0;
        end
        for (int k = 0; k < L; k++) begin
            if (op == 0) begin
                a = (dst + k) % 32; c = 1 + k;
                e_req[c] = 1; e_we[c] = 1; e_addr[c] = a; e_wd[c] = pat;
                refm[s][a] = pat;
            end else begin
                a = (src + k) % 32; c = 1 + k * W;
                e_req[c] = 1; e_addr[c] = a;
                if (op == 1) begin
                    cw = c + lat + 1; wa = (dst + k) % 32;
                    e_req[cw] = 1; e_we[cw] = 1; e_addr[cw] = wa; e_wd[cw] = refm[s][a];
                    refm[s][wa] = refm[s][a];
                end else if (refm[s][a] !== pat) begin
                    err++;
                end
            end
        end
        la = m_la[s];
        for (int i = 0; i <= D + 1; i++) begin
            if (e_req[i]) la = e_addr[i];
            else e_addr[i] = la;
        end
        m_la[s] = la;

        sel = s[0];
        cmd_op = op[1:0]; cmd_src = src[4:0]; cmd_dst = dst[4:0]; cmd_len = len[5:0]; cmd_pat = pat;
        cmd_valid = 1'b1;
        o_done = -1; o_err = -1;
        for (int i = 0; i <= D + 1; i++) begin
            @(negedge clk);
            cmp_cycle(i, D, err);
            if (d_done && o_done < 0) begin
                o_done = i; o_err = int'(d_err);
            end
            @(posedge clk);
            #1;
            if (junk && i + 1 <= D - 1) begin
                cmd_valid = 1'b1;
                cmd_op = 2'($urandom_range(0, 3)); cmd_src = 5'($urandom_range(0, 31));
                cmd_dst = 5'($urandom_range(0, 31)); cmd_len = 6'($urandom_range(0, 32));
                cmd_pat = $urandom;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        mem_cmp(s);
    endtask

    initial begin
        int od, oe, s, op, src, dst, len, ndone;
        logic [31:0] pat;
        n_checks = 0; n_err = 0;
        m_la[0] = 0; m_la[1] = 0;
        rst = 1'b1; sel = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_pat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready1", 32'(r1), 32'd0);
        chk("rst_ready0", 32'(r0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(d_ready), 32'd1);
        chk("post_rst_busy",  32'(d_busy), 32'd0);
        chk("post_rst_done",  32'(d_done), 32'd0);
        chk("post_rst_req",   32'(d_req), 32'd0);
        chk("post_rst_be",    32'(d_be), 32'd0);
        chk("post_rst_addr",  32'(d_addr), 32'd0);
        chk("post_rst_wdata", d_wdata, 32'd0);
        chk("post_rst_err",   32'(d_err), 32'd0);
        @(posedge clk);
        #1;

        run(1, 0, 0, 0, 32, 32'h0BAD_F00D, 0, od, oe);
        chk("init_fill_done", od, 33);
        run(0, 0, 0, 0, 32, 32'h1357_9BDF, 0, od, oe);

        run(1, 0, 0, 4, 8, 32'hA5A5_0001, 0, od, oe);
        chk("fill_done", od, 9);
        chk("fill_w4",  mem1[4],  32'hA5A5_0001);
        chk("fill_w11", mem1[11], 32'hA5A5_0001);
        chk("fill_w3",  mem1[3],  32'h0BAD_F00D);
        chk("fill_w12", mem1[12], 32'h0BAD_F00D);

        run(1, 1, 4, 20, 8, 32'h0, 0, od, oe);
        chk("copy_done", od, 25);
        chk("copy_w20", mem1[20], 32'hA5A5_0001);
        chk("copy_w27", mem1[27], 32'hA5A5_0001);

        run(1, 0, 0, 30, 4, 32'h0000_1234, 0, od, oe);
        chk("wrap_fill_done", od, 5);
        chk("wrap_w31", mem1[31], 32'h0000_1234);
        chk("wrap_w0",  mem1[0],  32'h0000_1234);
        run(1, 2, 30, 0, 4, 32'h0000_1234, 0, od, oe);
        chk("wrap_check_err", oe, 0);
        chk("wrap_check_done", od, 9);

        run(1, 0, 0, 6, 1, 32'h0, 0, od, oe);
        run(1, 2, 4, 0, 8, 32'hA5A5_0001, 0, od, oe);
        chk("check_err", oe, 1);
        chk("check_done", od, 17);

        run(1, 0, 3, 3, 0, 32'hFFFF_FFFF, 0, od, oe);
        chk("len0_done", od, 1);
        run(1, 3, 0, 0, 5, 32'hFFFF_FFFF, 0, od, oe);
        chk("op3_done", od, 1);

        run(0, 0, 0, 4, 8, 32'hA5A5_0001, 0, od, oe);
        chk("lat0_fill_done", od, 9);
        run(0, 1, 4, 20, 8, 32'h0, 0, od, oe);
        chk("lat0_copy_done", od, 17);
        chk("lat0_copy_w27", mem0[27], 32'hA5A5_0001);

        for (int i = 0; i < 40; i++) begin
            s   = $urandom_range(0, 1);
            op  = $urandom_range(0, 3);
            src = $urandom_range(0, 31);
            dst = $urandom_range(0, 31);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 32);
            pat = ($urandom_range(0, 1) == 1) ? refm[s][src] : $urandom;
            run(s, op, src, dst, len, pat, 1, od, oe);
        end

        // Abort a latency-1 fill in the middle of its fifth write cycle.
        sel = 1'b1;
        cmd_op = 2'd0; cmd_src = '0; cmd_dst = 5'd4; cmd_len = 6'd8; cmd_pat = 32'hC0DE_0005;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_pre_req",  32'(d_req), 32'd1);
        chk("abort_pre_addr", 32'(d_addr), 32'd8);
        rst = 1'b1;
        #1;
        chk("abort_req",   32'(d_req), 32'd0);
        chk("abort_busy",  32'(d_busy), 32'd0);
        chk("abort_ready", 32'(d_ready), 32'd0);
        chk("abort_addr",  32'(d_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_ready_after", 32'(d_ready), 32'd1);
        for (int a = 4; a < 8; a++) refm[1][a] = 32'hC0DE_0005;
        mem_cmp(1);
        mem_cmp(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
